// File: rtl/gpu_prim_sequencer.sv
// rtl/gpu_prim_sequencer.sv - GP0 primitive word sequencer for triangles, quads, rects and fills
// Pops command/parameter words from the GP0 FIFO and steers them to primitive registers.

module gpu_prim_sequencer (
   input  logic        i_clk,
   input  logic        i_nRst,
   input  logic        i_fifoValid,
   input  logic [31:0] i_fifoData,
   output logic        o_fifoRead,
   output logic        o_validData,
   output logic [31:0] o_data,
   output logic [7:0]  o_command,
   output logic [1:0]  o_targetVertex,
   output logic        o_loadVertices,
   output logic        o_loadUV,
   output logic        o_loadRGB,
   output logic        o_loadAllRGB,
   output logic        o_loadCoord1,
   output logic        o_loadCoord2,
   output logic        o_loadSize,
   output logic        o_loadRectEdge,
   output logic        o_isVertexLoadState,
   output logic [1:0]  o_loadSizeParam,
   output logic        o_primValid,
   input  logic        i_primAck,
   output logic [1:0]  o_primKind,
   output logic        o_busy,
   output logic        o_unsupported
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_COLOR  = 3'd1;
   localparam logic [2:0] S_VERTEX = 3'd2;
   localparam logic [2:0] S_UV     = 3'd3;
   localparam logic [2:0] S_SIZE   = 3'd4;
   localparam logic [2:0] S_ISSUE  = 3'd5;

   localparam logic [1:0] KIND_TRI  = 2'd0;
   localparam logic [1:0] KIND_RECT = 2'd1;
   localparam logic [1:0] KIND_FILL = 2'd2;

   logic [2:0] state, stateNext;
   logic [7:0] cmd, cmdNext;
   logic [1:0] vtxIdx, vtxIdxNext;
   logic       quadPhase, quadPhaseNext;
   logic       primValidNext;
   logic [1:0] primKindNext;
   logic       unsupportedNext;

   logic [7:0] activeCmd;
   logic       isPoly, isRect, isFill;
   logic       gouraud, quad, tex;
   logic [1:0] sizeField;
   logic       lastVertex;
   logic       pop;
   logic       vertexDone, primDone;
   logic [1:0] doneKind;

   // In S_IDLE the head word is the command being decoded; afterwards the latched copy rules.
   assign activeCmd  = (state == S_IDLE) ? i_fifoData[31:24] : cmd;
   assign isPoly     = (activeCmd[7:5] == 3'b001);
   assign isRect     = (activeCmd[7:5] == 3'b011);
   assign isFill     = (activeCmd == 8'h02);
   assign gouraud    = activeCmd[4];
   assign quad       = activeCmd[3];
   assign tex        = activeCmd[2];
   assign sizeField  = activeCmd[4:3];
   assign lastVertex = quadPhase || (vtxIdx == 2'd2);

   // Reset gating keeps the FIFO untouched while i_nRst is held low.
   assign pop = i_nRst && i_fifoValid && !o_primValid && (state != S_ISSUE);

   assign o_fifoRead      = pop;
   assign o_validData     = pop;
   assign o_data          = i_fifoData;
   assign o_command       = activeCmd;
   assign o_loadCoord2    = 1'b0;
   assign o_loadSizeParam = isRect ? sizeField : 2'd0;
   assign o_busy          = (state != S_IDLE);

   always_comb begin
      stateNext           = state;
      cmdNext             = cmd;
      vtxIdxNext          = vtxIdx;
      quadPhaseNext       = quadPhase;
      primValidNext       = o_primValid;
      primKindNext        = o_primKind;
      unsupportedNext     = 1'b0;
      vertexDone          = 1'b0;
      primDone            = 1'b0;
      doneKind            = KIND_TRI;
      o_targetVertex      = 2'd0;
      o_loadVertices      = 1'b0;
      o_loadUV            = 1'b0;
      o_loadRGB           = 1'b0;
      o_loadAllRGB        = 1'b0;
      o_loadCoord1        = 1'b0;
      o_loadSize          = 1'b0;
      o_loadRectEdge      = 1'b0;
      o_isVertexLoadState = 1'b0;

      case (state)
         S_IDLE: begin
            if (pop) begin
               if (isPoly || isRect || isFill) begin
                  o_loadRGB     = 1'b1;
                  o_loadAllRGB  = !(isPoly && gouraud);
                  cmdNext       = i_fifoData[31:24];
                  vtxIdxNext    = 2'd0;
                  quadPhaseNext = 1'b0;
                  stateNext     = S_VERTEX;
               end else begin
                  unsupportedNext = 1'b1;
               end
            end
         end

         S_COLOR: begin
            if (pop) begin
               o_loadRGB      = 1'b1;
               o_targetVertex = vtxIdx;
               stateNext      = S_VERTEX;
            end
         end

         S_VERTEX: begin
            if (pop) begin
               if (isFill) begin
                  o_loadCoord1 = 1'b1;
                  stateNext    = S_SIZE;
               end else begin
                  o_loadVertices      = 1'b1;
                  o_isVertexLoadState = 1'b1;
                  o_targetVertex      = vtxIdx;
                  if (isRect) begin
                     // Fixed-size rects carry their extent implicitly in the vertex word.
                     if (sizeField != 2'd0) begin
                        o_loadSize     = 1'b1;
                        o_loadRectEdge = 1'b1;
                     end
                     if (tex)
                        stateNext = S_UV;
                     else if (sizeField == 2'd0)
                        stateNext = S_SIZE;
                     else begin
                        primDone = 1'b1;
                        doneKind = KIND_RECT;
                     end
                  end else if (tex) begin
                     stateNext = S_UV;
                  end else begin
                     vertexDone = 1'b1;
                  end
               end
            end
         end

         S_UV: begin
            if (pop) begin
               o_loadUV       = 1'b1;
               o_targetVertex = vtxIdx;
               if (isRect) begin
                  if (sizeField == 2'd0)
                     stateNext = S_SIZE;
                  else begin
                     primDone = 1'b1;
                     doneKind = KIND_RECT;
                  end
               end else begin
                  vertexDone = 1'b1;
               end
            end
         end

         S_SIZE: begin
            if (pop) begin
               o_loadSize     = 1'b1;
               o_loadRectEdge = isRect;
               primDone       = 1'b1;
               doneKind       = isRect ? KIND_RECT : KIND_FILL;
            end
         end

         S_ISSUE: begin
            if (i_primAck && o_primValid) begin
               primValidNext = 1'b0;
               // Second half of a quad reuses slot 0 for vertex 3.
               if (isPoly && quad && !quadPhase) begin
                  quadPhaseNext = 1'b1;
                  vtxIdxNext    = 2'd0;
                  stateNext     = gouraud ? S_COLOR : S_VERTEX;
               end else begin
                  quadPhaseNext = 1'b0;
                  stateNext     = S_IDLE;
               end
            end
         end

         default: stateNext = S_IDLE;
      endcase

      if (vertexDone) begin
         if (lastVertex) begin
            primDone = 1'b1;
            doneKind = KIND_TRI;
         end else begin
            vtxIdxNext = vtxIdx + 2'd1;
            stateNext  = gouraud ? S_COLOR : S_VERTEX;
         end
      end

      if (primDone) begin
         stateNext     = S_ISSUE;
         primValidNext = 1'b1;
         primKindNext  = doneKind;
      end
   end

   always_ff @(posedge i_clk or negedge i_nRst) begin
      if (!i_nRst) begin
         state         <= S_IDLE;
         cmd           <= 8'h00;
         vtxIdx        <= 2'd0;
         quadPhase     <= 1'b0;
         o_primValid   <= 1'b0;
         o_primKind    <= 2'd0;
         o_unsupported <= 1'b0;
      end else begin
         state         <= stateNext;
         cmd           <= cmdNext;
         vtxIdx        <= vtxIdxNext;
         quadPhase     <= quadPhaseNext;
         o_primValid   <= primValidNext;
         o_primKind    <= primKindNext;
         o_unsupported <= unsupportedNext;
      end
   end

endmodule

// File: tb/tb_gpu_prim_sequencer.sv
// tb/tb_gpu_prim_sequencer.sv - directed bench for gpu_prim_sequencer
// Inputs change on the falling edge; outputs are sampled 1 time unit later.

module tb_gpu_prim_sequencer;

   logic        clk = 1'b0;
   logic        rstN;
   logic        fifoValid;
   logic [31:0] fifoData;
   logic        primAck;
   logic        fifoRead, validData;
   logic [31:0] data;
   logic [7:0]  command;
   logic [1:0]  targetVertex;
   logic        loadVertices, loadUV, loadRGB, loadAllRGB, loadCoord1, loadCoord2;
   logic        loadSize, loadRectEdge, isVertexLoadState;
   logic [1:0]  loadSizeParam;
   logic        primValid;
   logic [1:0]  primKind;
   logic        busy, unsupported;
   logic [8:0]  strobes;

   int checks = 0;
   int errors = 0;

   localparam logic [8:0] S_NONE   = 9'h000;
   localparam logic [8:0] S_POP    = 9'h100;
   localparam logic [8:0] S_RGBALL = 9'h130;
   localparam logic [8:0] S_RGB    = 9'h120;
   localparam logic [8:0] S_VTX    = 9'h181;
   localparam logic [8:0] S_UV     = 9'h140;
   localparam logic [8:0] S_VTXSZ  = 9'h187;
   localparam logic [8:0] S_SZRE   = 9'h106;
   localparam logic [8:0] S_COORD  = 9'h108;
   localparam logic [8:0] S_SZ     = 9'h104;

   always #5 clk = ~clk;

   assign strobes = {fifoRead, loadVertices, loadUV, loadRGB, loadAllRGB,
                     loadCoord1, loadSize, loadRectEdge, isVertexLoadState};

   gpu_prim_sequencer dut (
      .i_clk              (clk),
      .i_nRst             (rstN),
      .i_fifoValid        (fifoValid),
      .i_fifoData         (fifoData),
      .o_fifoRead         (fifoRead),
      .o_validData        (validData),
      .o_data             (data),
      .o_command          (command),
      .o_targetVertex     (targetVertex),
      .o_loadVertices     (loadVertices),
      .o_loadUV           (loadUV),
      .o_loadRGB          (loadRGB),
      .o_loadAllRGB       (loadAllRGB),
      .o_loadCoord1       (loadCoord1),
      .o_loadCoord2       (loadCoord2),
      .o_loadSize         (loadSize),
      .o_loadRectEdge     (loadRectEdge),
      .o_isVertexLoadState(isVertexLoadState),
      .o_loadSizeParam    (loadSizeParam),
      .o_primValid        (primValid),
      .i_primAck          (primAck),
      .o_primKind         (primKind),
      .o_busy             (busy),
      .o_unsupported      (unsupported)
   );

   task automatic drive(input logic v, input logic [31:0] d, input logic ack);
      @(negedge clk);
      fifoValid = v;
      fifoData  = d;
      primAck   = ack;
      #1;
   endtask

   task automatic test_reset;
      rstN = 1'b0; fifoValid = 1'b1; fifoData = 32'h20FF8040; primAck = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (strobes !== S_NONE) begin errors++; $display("FAIL reset_strobes got %h want %h", strobes, S_NONE); end
      checks++; if ({primValid, busy, primKind, unsupported} !== 5'b0) begin errors++; $display("FAIL reset_regs got %b want 00000", {primValid, busy, primKind, unsupported}); end
      checks++; if (command !== 8'h20) begin errors++; $display("FAIL reset_command got %h want 20", command); end
      @(negedge clk);
      rstN = 1'b1; fifoValid = 1'b0;
   endtask

   task automatic test_flat_triangle;
      logic [31:0] w [4];
      int allCnt = 0;
      w = '{32'h20FF8040, 32'h00100010, 32'h00200030, 32'h00400050};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, w[i], 1'b0);
         allCnt += int'(loadAllRGB);
         checks++; if (strobes !== ((i == 0) ? S_RGBALL : S_VTX)) begin errors++; $display("FAIL tri_strobe%0d got %h want %h", i, strobes, (i == 0) ? S_RGBALL : S_VTX); end
         checks++; if (targetVertex !== ((i == 0) ? 2'd0 : 2'(i - 1))) begin errors++; $display("FAIL tri_target%0d got %0d want %0d", i, targetVertex, (i == 0) ? 0 : i - 1); end
         checks++; if (data !== w[i]) begin errors++; $display("FAIL tri_data%0d got %h want %h", i, data, w[i]); end
      end
      checks++; if (allCnt != 1) begin errors++; $display("FAIL tri_allrgb_count got %0d want 1", allCnt); end
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h02000000, 1'b0);
         checks++; if ({primValid, fifoRead, primKind, busy} !== 5'b10001) begin errors++; $display("FAIL tri_hold%0d got %b want 10001", k, {primValid, fifoRead, primKind, busy}); end
      end
      drive(1'b1, 32'h02000000, 1'b1);
      checks++; if (fifoRead !== 1'b0) begin errors++; $display("FAIL tri_ack_pop got %b want 0", fifoRead); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, busy} !== 2'b00) begin errors++; $display("FAIL tri_after_ack got %b want 00", {primValid, busy}); end
   endtask

   task automatic test_gouraud_quad;
      logic [8:0] expS [9];
      logic [1:0] expT [9];
      logic [8:0] contS [3];
      expS = '{S_RGB, S_VTX, S_UV, S_RGB, S_VTX, S_UV, S_RGB, S_VTX, S_UV};
      expT = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
      contS = '{S_RGB, S_VTX, S_UV};
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, (i == 0) ? 32'h3C112233 : (32'h00010001 * i), 1'b0);
         checks++; if (strobes !== expS[i]) begin errors++; $display("FAIL quad_strobe%0d got %h want %h", i, strobes, expS[i]); end
         checks++; if (targetVertex !== expT[i]) begin errors++; $display("FAIL quad_target%0d got %0d want %0d", i, targetVertex, expT[i]); end
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'hAAAA0000, 1'b0);
         checks++; if ({primValid, fifoRead} !== 2'b10) begin errors++; $display("FAIL quad_wait%0d got %b want 10", k, {primValid, fifoRead}); end
      end
      drive(1'b1, 32'hAAAA0000, 1'b1);
      checks++; if (fifoRead !== 1'b0) begin errors++; $display("FAIL quad_ack_pop got %b want 0", fifoRead); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h00300030 + i, 1'b0);
         checks++; if (strobes !== contS[i]) begin errors++; $display("FAIL quad_cont_strobe%0d got %h want %h", i, strobes, contS[i]); end
         checks++; if (targetVertex !== 2'd0) begin errors++; $display("FAIL quad_cont_target%0d got %0d want 0", i, targetVertex); end
      end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, primKind, busy} !== 4'b1001) begin errors++; $display("FAIL quad_second_issue got %b want 1001", {primValid, primKind, busy}); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, busy} !== 2'b00) begin errors++; $display("FAIL quad_done got %b want 00", {primValid, busy}); end
   endtask

   task automatic test_rect;
      drive(1'b1, 32'h78000000, 1'b0);
      checks++; if (strobes !== S_RGBALL) begin errors++; $display("FAIL rect_cmd got %h want %h", strobes, S_RGBALL); end
      checks++; if (loadSizeParam !== 2'd3) begin errors++; $display("FAIL rect_param_cmd got %0d want 3", loadSizeParam); end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 32'h00200010, 1'b0);
         checks++; if ({strobes, busy} !== 10'h001) begin errors++; $display("FAIL rect_stall%0d got %h want 001", k, {strobes, busy}); end
      end
      drive(1'b1, 32'h00200010, 1'b0);
      checks++; if (strobes !== S_VTXSZ) begin errors++; $display("FAIL rect_vtx got %h want %h", strobes, S_VTXSZ); end
      checks++; if (loadSizeParam !== 2'd3) begin errors++; $display("FAIL rect_param_vtx got %0d want 3", loadSizeParam); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, primKind} !== 3'b101) begin errors++; $display("FAIL rect_issue got %b want 101", {primValid, primKind}); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b1, 32'h64000000, 1'b0);
      checks++; if ({strobes, loadSizeParam} !== {S_RGBALL, 2'd0}) begin errors++; $display("FAIL vrect_cmd got %h want %h", {strobes, loadSizeParam}, {S_RGBALL, 2'd0}); end
      drive(1'b1, 32'h00400040, 1'b0);
      checks++; if (strobes !== S_VTX) begin errors++; $display("FAIL vrect_vtx got %h want %h", strobes, S_VTX); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if (strobes !== S_NONE) begin errors++; $display("FAIL vrect_stall got %h want %h", strobes, S_NONE); end
      drive(1'b1, 32'h00001234, 1'b0);
      checks++; if (strobes !== S_UV) begin errors++; $display("FAIL vrect_uv got %h want %h", strobes, S_UV); end
      drive(1'b1, 32'h00100020, 1'b0);
      checks++; if ({strobes, loadSizeParam} !== {S_SZRE, 2'd0}) begin errors++; $display("FAIL vrect_size got %h want %h", {strobes, loadSizeParam}, {S_SZRE, 2'd0}); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, primKind} !== 3'b101) begin errors++; $display("FAIL vrect_issue got %b want 101", {primValid, primKind}); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
   endtask

   task automatic test_fill;
      drive(1'b1, 32'h02102030, 1'b0);
      checks++; if (strobes !== S_RGBALL) begin errors++; $display("FAIL fill_color got %h want %h", strobes, S_RGBALL); end
      drive(1'b1, 32'h00100025, 1'b0);
      checks++; if (strobes !== S_COORD) begin errors++; $display("FAIL fill_coord got %h want %h", strobes, S_COORD); end
      drive(1'b1, 32'h00080013, 1'b0);
      checks++; if ({strobes, loadSizeParam} !== {S_SZ, 2'd0}) begin errors++; $display("FAIL fill_size got %h want %h", {strobes, loadSizeParam}, {S_SZ, 2'd0}); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, primKind} !== 3'b110) begin errors++; $display("FAIL fill_issue got %b want 110", {primValid, primKind}); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, busy} !== 2'b00) begin errors++; $display("FAIL fill_done got %b want 00", {primValid, busy}); end
   endtask

   task automatic test_unsupported;
      drive(1'b1, 32'hE1000000, 1'b0);
      checks++; if ({strobes, busy} !== {S_POP, 1'b0}) begin errors++; $display("FAIL unsup_pop got %h want %h", {strobes, busy}, {S_POP, 1'b0}); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({unsupported, busy} !== 2'b10) begin errors++; $display("FAIL unsup_pulse got %b want 10", {unsupported, busy}); end
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({unsupported, busy} !== 2'b00) begin errors++; $display("FAIL unsup_clear got %b want 00", {unsupported, busy}); end
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 32'h20FF8040, 1'b0);
      drive(1'b1, 32'h00100010, 1'b0);
      @(negedge clk);
      rstN = 1'b0; fifoValid = 1'b1; fifoData = 32'h00200030;
      #1;
      checks++; if ({strobes, primValid, busy, unsupported, primKind} !== 14'h0) begin errors++; $display("FAIL rstmid_async got %h want 0", {strobes, primValid, busy, unsupported, primKind}); end
      @(negedge clk);
      #1;
      checks++; if ({strobes, busy} !== 10'h0) begin errors++; $display("FAIL rstmid_held got %h want 0", {strobes, busy}); end
      @(negedge clk);
      rstN = 1'b1; fifoValid = 1'b1; fifoData = 32'h02000000;
      #1;
      checks++; if ({strobes, command} !== {S_RGBALL, 8'h02}) begin errors++; $display("FAIL rstmid_decode got %h want %h", {strobes, command}, {S_RGBALL, 8'h02}); end
      drive(1'b1, 32'h00000000, 1'b0);
      drive(1'b1, 32'h00010001, 1'b0);
      drive(1'b0, 32'h0, 1'b0);
      checks++; if ({primValid, primKind} !== 3'b110) begin errors++; $display("FAIL rstmid_fill got %b want 110", {primValid, primKind}); end
      drive(1'b0, 32'h0, 1'b1);
      drive(1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_flat_triangle();
      test_gouraud_quad();
      test_rect();
      test_fill();
      test_unsupported();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
